// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_arbiter.
// slave: the arbiter's view; master: the CPU/memory-model side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, err;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        grant;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    output ack0, ack1, err, rdata, grant, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    input  ack0, ack1, err, rdata, grant, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, variable-latency memory,
// with a watchdog that aborts a transaction after TIMEOUT cycles without mem_ready.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;       // 1 = port 1 was granted last
  logic [1:0]        r_grant;
  logic              r_ack0, r_ack1, r_err;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_win;        // 1 = port 1 wins

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign w_win = bus.req1 & (~bus.req0 | ~r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_grant     <= 2'b00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            r_grant     <= w_win ? 2'b10 : 2'b01;
            r_last      <= w_win;
            r_mem_we    <= w_win ? bus.we1    : bus.we0;
            r_mem_addr  <= w_win ? bus.addr1  : bus.addr0;
            r_mem_wdata <= w_win ? bus.wdata1 : bus.wdata0;
            r_mem_req   <= 1'b1;
            r_cnt       <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_rdata   <= r_mem_we ? '0 : bus.mem_rdata;
            r_err     <= 1'b0;
            r_ack0    <= r_grant[0];
            r_ack1    <= r_grant[1];
            r_state   <= ACK;
          end else if (r_cnt == CNT_MAX) begin
            r_mem_req <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_ack0    <= r_grant[0];
            r_ack1    <= r_grant[1];
            r_state   <= ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACK: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err   <= 1'b0;
          r_grant <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter that shares a single-port, variable-latency memory between the instruction-fetch port (port 0) and the load/store port (port 1) of the lab CPU. Each granted access is registered toward the memory, held until the memory signals ready or a watchdog expires, and then acknowledged to the owner with a one-cycle pulse. It sits between the CPU core and the memory model and is exercised by a standalone `clk`-driven bench.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles waiting for mem_ready before abort (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  request, held until matching ack
- we0, we1  in  1 each  1 = write, 0 = read; stable while req high
- addr0, addr1  in  ADDR_W each  address; stable while req high
- wdata0, wdata1  in  DATA_W each  write data; stable while req high
- ack0, ack1  out  1 each  one-cycle completion pulse
- err  out  1  valid with ack; 1 = transaction timed out
- rdata  out  DATA_W  read data, valid in ack cycle (shared by both ports)
- grant  out  2  one-hot owner of the current transaction, 0 when idle
- mem_req  out  1  memory request, held until mem_ready or timeout
- mem_we  out  1  registered copy of owner's we
- mem_addr  out  ADDR_W  registered copy of owner's addr
- mem_wdata  out  DATA_W  registered copy of owner's wdata
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, sampled only while mem_req high

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: no request → stay. Any request → choose winner, latch we/addr/wdata into mem_* regs, set grant, set mem_req, clear wait counter, go WAIT.
- Winner: only one requesting → that one. Both → the port not granted last (last_grant pointer). Pointer updates at every grant; reset value = port 1, so port 0 wins the first tie.
- WAIT: mem_req high, mem_* stable. mem_ready=1 → clear mem_req, register rdata = mem_rdata (reads; writes give rdata = 0), err=0, pulse ack of owner, go ACK. Else counter increments; when counter reaches TIMEOUT−1 with no mem_ready → clear mem_req, rdata=0, err=1, pulse ack, go ACK.
- ACK: ack/err high for exactly this cycle, no arbitration (requester drops req during it), then go IDLE and clear grant.
- Requests asserted during WAIT/ACK are held by the requester and arbitrated in the next IDLE; none are lost.
- Counter width = $clog2(TIMEOUT+1); no wrap possible before abort.

## Timing
- Reset (async, immediate): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, ack0=ack1=0, err=0, grant=0, counter=0, last_grant=port 1. Reset during WAIT abandons the transaction with no ack.
- req sampled at edge E0 → mem_req high from E0. mem_ready high in the first WAIT cycle → ack high in the following cycle (cycle after mem_ready edge), IDLE next. Minimum issue-to-issue spacing: 3 cycles.
- Timeout: ack with err=1 occurs exactly TIMEOUT cycles after mem_req rises.
- mem_ready while not in WAIT is ignored. ack0 and ack1 never both high; ack never high outside ACK.

## Test plan
- Single read: req0, addr0=0x100; mem_ready after 2 cycles, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, grant=01, ack0 one cycle with rdata=0xDEADBEEF, err=0.
- Tie then alternation: req0 and req1 held continuously, memory ready in 1 cycle → grants in order 0,1,0,1; each ack 3 cycles apart; ack0/ack1 never overlap.
- Write: req1, we1=1, addr1=0x20, wdata1=0x55AA → mem_we=1, mem_wdata=0x55AA; ack1 with rdata=0.
- Timeout: req0, mem_ready held 0 → mem_req drops and ack0=1, err=1 exactly 15 cycles after mem_req rise; next request then proceeds normally.
- Reset mid-WAIT: assert rst 2 cycles into WAIT → all outputs 0 at once, no ack; after release, tie goes to port 0.
- Back-to-back single requester: req1 re-asserted right after ack1, port 0 idle → port 1 granted again in next IDLE cycle.
